// File: rtl/weight_mem.sv
// Burst-loaded weight memory with NUM_RD independent registered read ports.
// Optional macro WEIGHT_MEM_BYPASS_EN forwards same-cycle write data to readers.
module weight_mem #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned NUM_RD     = 2,
  parameter string       INIT_FILE  = ""
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         load_start,
  input  logic [ADDR_WIDTH-1:0]        load_base,
  input  logic [ADDR_WIDTH:0]          load_len,
  input  logic                         s_valid,
  input  logic [DATA_WIDTH-1:0]        s_data,
  output logic                         s_ready,
  output logic                         load_busy,
  output logic                         load_done,
  input  logic [NUM_RD-1:0]            rd_en,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr,
  output logic [NUM_RD*DATA_WIDTH-1:0] rd_data,
  output logic [NUM_RD-1:0]            rd_valid,
  output logic [NUM_RD-1:0]            rd_err
);

  localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {StIdle, StLoad, StDone} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
  logic [ADDR_WIDTH:0]   rem_q, rem_d;
  logic                  wr_en;
  logic                  wr_fire;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_comb begin
    state_d   = state_q;
    wptr_d    = wptr_q;
    rem_d     = rem_q;
    s_ready   = 1'b0;
    load_busy = 1'b0;
    load_done = 1'b0;
    wr_en     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (load_start) begin
          if (load_len != '0) begin
            state_d = StLoad;
            wptr_d  = load_base;
            rem_d   = load_len;
          end else begin
            state_d = StDone;
          end
        end
      end
      StLoad: begin
        s_ready   = 1'b1;
        load_busy = 1'b1;
        if (s_valid) begin
          wr_en  = 1'b1;
          wptr_d = (wptr_q == ADDR_WIDTH'(DEPTH - 1)) ? '0 : wptr_q + 1'b1;
          rem_d  = rem_q - 1'b1;
          if (rem_q == (ADDR_WIDTH + 1)'(1)) state_d = StDone;
        end
      end
      StDone: begin
        load_done = 1'b1;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      wptr_q  <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      rem_q   <= rem_d;
    end
  end

  // A beat in the reset cycle is dropped; the array itself is never reset.
  assign wr_fire = wr_en && !rst;

  always_ff @(posedge clk) begin
    if (wr_fire) mem[wptr_q[IdxW-1:0]] <= s_data;
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_WIDTH-1:0] addr;
    logic                  in_range;
    logic [DATA_WIDTH-1:0] word;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  valid_q;
    logic                  err_q;

    assign addr     = rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign in_range = {1'b0, addr} < (ADDR_WIDTH + 1)'(DEPTH);

    always_comb begin
      word = in_range ? mem[addr[IdxW-1:0]] : '0;
`ifdef WEIGHT_MEM_BYPASS_EN
      if (wr_fire && in_range && (addr == wptr_q)) word = s_data;
`endif
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        data_q  <= '0;
        valid_q <= 1'b0;
        err_q   <= 1'b0;
      end else begin
        valid_q <= rd_en[i];
        err_q   <= rd_en[i] & ~in_range;
        if (rd_en[i]) data_q <= word;
      end
    end

    assign rd_data[i*DATA_WIDTH +: DATA_WIDTH] = data_q;
    assign rd_valid[i] = valid_q;
    assign rd_err[i]   = err_q;
  end

endmodule

// File: tb/tb_weight_mem.sv
// Directed self-checking bench for weight_mem (ADDR_WIDTH=5, DEPTH=16, two read ports).
module tb_weight_mem;
  localparam int unsigned AW = 5;
  localparam int unsigned DW = 16;
  localparam int unsigned NR = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          load_start;
  logic [AW-1:0] load_base;
  logic [AW:0]   load_len;
  logic          s_valid;
  logic [DW-1:0] s_data;
  logic          s_ready, load_busy, load_done;
  logic [NR-1:0] rd_en;
  logic [NR*AW-1:0] rd_addr;
  logic [NR*DW-1:0] rd_data;
  logic [NR-1:0] rd_valid, rd_err;

  int n_checks = 0;
  int n_fail   = 0;

  weight_mem #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(16), .NUM_RD(NR), .INIT_FILE("")
  ) dut (
    .clk(clk), .rst(rst), .load_start(load_start), .load_base(load_base),
    .load_len(load_len), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .load_busy(load_busy), .load_done(load_done), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_err(rd_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic rd2(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    rd_en   = 2'b11;
    rd_addr = {a1, a0};
    tick();
    rd_en   = 2'b00;
  endtask

  // Single-word load: start, one beat, then let DONE return to IDLE.
  task automatic load_word(input logic [AW-1:0] base, input logic [DW-1:0] d);
    load_start = 1'b1; load_base = base; load_len = 6'd1;
    tick();
    load_start = 1'b0;
    s_valid = 1'b1; s_data = d;
    tick();
    s_valid = 1'b0;
    tick();
  endtask

  logic [DW-1:0] exp_fwd;

  initial begin
    rst = 1'b1; load_start = 1'b0; load_base = '0; load_len = '0;
    s_valid = 1'b0; s_data = '0; rd_en = '0; rd_addr = '0;
    tick(); tick();
    rst = 1'b0;
    chk("reset_s_ready", 32'(s_ready), 32'd0);
    chk("reset_busy", 32'(load_busy), 32'd0);
    chk("reset_done", 32'(load_done), 32'd0);
    chk("reset_rd_valid", 32'(rd_valid), 32'd0);
    chk("reset_rd_err", 32'(rd_err), 32'd0);
    chk("reset_rd_data", rd_data, 32'd0);

    // Continuous burst: base 3, four words.
    load_start = 1'b1; load_base = 5'd3; load_len = 6'd4;
    tick();
    load_start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("burst_busy", 32'(load_busy), 32'd1);
      chk("burst_ready", 32'(s_ready), 32'd1);
      s_valid = 1'b1; s_data = 16'h00A1 + 16'(k);
      tick();
    end
    s_valid = 1'b0;
    chk("burst_done_pulse", 32'(load_done), 32'd1);
    chk("burst_busy_off", 32'(load_busy), 32'd0);
    chk("burst_ready_done", 32'(s_ready), 32'd0);
    tick();
    chk("burst_done_once", 32'(load_done), 32'd0);
    rd2(5'd3, 5'd4);
    chk("burst_mem3_4", rd_data, 32'h00A2_00A1);
    chk("burst_valid", 32'(rd_valid), 32'd3);
    rd2(5'd5, 5'd6);
    chk("burst_mem5_6", rd_data, 32'h00A4_00A3);

    // Wrapping burst with gapped s_valid: 14,15,0,1.
    load_start = 1'b1; load_base = 5'd14; load_len = 6'd4;
    tick();
    load_start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      chk("wrap_ready_held", 32'(s_ready), 32'd1);
      s_valid = (i % 2 == 0);
      s_data  = 16'h00B0 + 16'(i / 2);
      tick();
    end
    s_valid = 1'b0;
    chk("wrap_done", 32'(load_done), 32'd1);
    tick();
    rd2(5'd14, 5'd15);
    chk("wrap_mem14_15", rd_data, 32'h00B1_00B0);
    rd2(5'd0, 5'd1);
    chk("wrap_mem0_1", rd_data, 32'h00B3_00B2);
    rd2(5'd3, 5'd6);
    chk("wrap_no_spill", rd_data, 32'h00A4_00A1);

    // Out-of-range port 1 alongside in-range port 0.
    rd2(5'd5, 5'd20);
    chk("oor_data", rd_data, 32'h0000_00A3);
    chk("oor_err", 32'(rd_err), 32'd2);
    chk("oor_valid", 32'(rd_valid), 32'd3);
    tick();
    chk("idle_valid_low", 32'(rd_valid), 32'd0);
    chk("idle_err_low", 32'(rd_err), 32'd0);
    chk("idle_data_hold", rd_data, 32'h0000_00A3);

    // Same-cycle read/write collision at address 7.
    load_word(5'd7, 16'hBEEF);
    load_start = 1'b1; load_base = 5'd7; load_len = 6'd1;
    tick();
    load_start = 1'b0;
    s_valid = 1'b1; s_data = 16'h1234;
    rd_en = 2'b01; rd_addr = {5'd0, 5'd7};
    tick();
    s_valid = 1'b0; rd_en = 2'b00;
`ifdef WEIGHT_MEM_BYPASS_EN
    exp_fwd = 16'h1234;
`else
    exp_fwd = 16'hBEEF;
`endif
    chk("collide_port0", 32'(rd_data[DW-1:0]), 32'(exp_fwd));
    tick();
    rd2(5'd7, 5'd7);
    chk("collide_after", rd_data, 32'h1234_1234);

    // Reset mid-burst; beat presented during reset must not land.
    load_word(5'd10, 16'h5555);
    load_start = 1'b1; load_base = 5'd8; load_len = 6'd4;
    tick();
    load_start = 1'b0;
    s_valid = 1'b1; s_data = 16'h00C0; tick();
    s_data = 16'h00C1; tick();
    rst = 1'b1; s_data = 16'h00C2;
    tick();
    rst = 1'b0; s_valid = 1'b0;
    chk("abort_busy", 32'(load_busy), 32'd0);
    chk("abort_ready", 32'(s_ready), 32'd0);
    chk("abort_done", 32'(load_done), 32'd0);
    chk("abort_rd_out", {rd_data[15:0], 14'd0, rd_valid}, 32'd0);
    tick();
    chk("abort_no_done", 32'(load_done), 32'd0);
    rd2(5'd8, 5'd9);
    chk("abort_kept", rd_data, 32'h00C1_00C0);
    rd2(5'd10, 5'd11);
    chk("abort_reset_beat", 32'(rd_data[DW-1:0]), 32'h5555);

    // Zero-length load goes straight to DONE.
    load_start = 1'b1; load_base = 5'd0; load_len = 6'd0;
    chk("zero_ready_start", 32'(s_ready), 32'd0);
    tick();
    load_start = 1'b0;
    chk("zero_done", 32'(load_done), 32'd1);
    chk("zero_ready", 32'(s_ready), 32'd0);
    tick();
    chk("zero_done_once", 32'(load_done), 32'd0);
    rd2(5'd0, 5'd1);
    chk("zero_no_write", rd_data, 32'h00B3_00B2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
